// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder sequencing one full-adder cell LSB first.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, s_sh_q, sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, busy_q, done_q, cout_q;
    logic             s_d, c_d;
    logic [WIDTH:0]   sh_cat;
    logic [WIDTH-1:0] s_sh_d;
    always_comb begin
        s_d    = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        c_d    = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
        sh_cat = {s_d, s_sh_q};
        s_sh_d = sh_cat[WIDTH:1];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    a_sh_q  <= a;
                    b_sh_q  <= b;
                    carry_q <= cin;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= RUN;
                end
                RUN: begin
                    carry_q <= c_d;
                    s_sh_q  <= s_sh_d;
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        sum_q   <= s_sh_d;
                        cout_q  <= c_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed bench for WIDTH=8 and WIDTH=1 instances of serial_adder_ctrl.
module tb_serial_adder_ctrl;
    logic       clk, rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;
    int         n_cmp = 0, n_err = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );
    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                          output logic [7:0] s, output logic co, output int lat);
        @(negedge clk);
        a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = ~ia; b8 = ~ib; cin8 = ~ic;
        lat = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 40) lat = -1;
        s = sum8; co = cout8;
    endtask

    task automatic do_op1(input logic [2:0] v, output logic [1:0] r, output int lat);
        @(negedge clk);
        a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; a1 = ~v[2]; b1 = ~v[1]; cin1 = ~v[0];
        lat = 0;
        while (done1 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 20) lat = -1;
        r = {cout1, sum1};
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy8, done8, sum8, cout8} !== 11'h000) begin
                n_err++;
                $display("FAIL reset_idle8 cyc %0d: busy=%b done=%b sum=%h cout=%b, want all 0", i, busy8, done8, sum8, cout8);
            end
            n_cmp++;
            if ({busy1, done1, sum1, cout1} !== 4'h0) begin
                n_err++;
                $display("FAIL reset_idle1 cyc %0d: busy=%b done=%b sum=%h cout=%b, want all 0", i, busy1, done1, sum1, cout1);
            end
        end
    endtask

    task automatic test_basic;
        logic       eb, ed;
        logic [7:0] es;
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            start8 = 1'b0;
            eb = (k < 8);
            ed = (k == 8);
            es = (k < 8) ? 8'h00 : 8'h10;
            n_cmp++;
            if ({busy8, done8, sum8, cout8} !== {eb, ed, es, 1'b0}) begin
                n_err++;
                $display("FAIL basic k=%0d: busy=%b done=%b sum=%h cout=%b, want busy=%b done=%b sum=%h cout=0",
                         k, busy8, done8, sum8, cout8, eb, ed, es);
            end
        end
    endtask

    task automatic test_carry_chain;
        logic [7:0] s;
        logic       co;
        int         lat;
        do_op8(8'hFF, 8'h00, 1'b1, s, co, lat);
        n_cmp++;
        if ({lat, co, s} !== {32'd8, 1'b1, 8'h00}) begin
            n_err++;
            $display("FAIL chain_ff_00_1: lat=%0d cout=%b sum=%h, want lat=8 cout=1 sum=00", lat, co, s);
        end
        do_op8(8'hFF, 8'hFF, 1'b1, s, co, lat);
        n_cmp++;
        if ({lat, co, s} !== {32'd8, 1'b1, 8'hFF}) begin
            n_err++;
            $display("FAIL chain_ff_ff_1: lat=%0d cout=%b sum=%h, want lat=8 cout=1 sum=ff", lat, co, s);
        end
        do_op8(8'h3C, 8'h5A, 1'b0, s, co, lat);
        n_cmp++;
        if ({lat, co, s} !== {32'd8, 1'b0, 8'h96}) begin
            n_err++;
            $display("FAIL add_3c_5a_0: lat=%0d cout=%b sum=%h, want lat=8 cout=0 sum=96", lat, co, s);
        end
    endtask

    task automatic test_back_to_back;
        int last = -1, nd = 0;
        @(negedge clk);
        a8 = 8'h55; b8 = 8'hAA; cin8 = 1'b0; start8 = 1'b1;
        for (int k = 0; k < 40 && nd < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (busy8 && done8) begin
                n_err++;
                $display("FAIL b2b_overlap k=%0d: busy=1 done=1, want not both", k);
            end
            if (done8) begin
                n_cmp++;
                if ({cout8, sum8} !== 9'h0FF) begin
                    n_err++;
                    $display("FAIL b2b_result %0d: cout=%b sum=%h, want cout=0 sum=ff", nd, cout8, sum8);
                end
                if (last >= 0) begin
                    n_cmp++;
                    if (k - last !== 10) begin
                        n_err++;
                        $display("FAIL b2b_period %0d: got %0d cycles, want 10", nd, k - last);
                    end
                end
                last = k; nd++;
                a8 = 8'h55; b8 = 8'hAA; cin8 = 1'b0;
            end else if (busy8) begin
                a8 = 8'h0F; b8 = 8'h0F; cin8 = 1'b1;
            end
        end
        start8 = 1'b0;
        n_cmp++;
        if (nd !== 3) begin
            n_err++;
            $display("FAIL b2b_count: got %0d done pulses, want 3", nd);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [7:0] s;
        logic       co;
        int         lat;
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({busy8, done8, sum8, cout8} !== 11'h000) begin
            n_err++;
            $display("FAIL reset_mid: busy=%b done=%b sum=%h cout=%b, want all 0", busy8, done8, sum8, cout8);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy8, done8, sum8, cout8} !== 11'h000) begin
                n_err++;
                $display("FAIL reset_mid_quiet cyc %0d: busy=%b done=%b sum=%h cout=%b, want all 0", i, busy8, done8, sum8, cout8);
            end
        end
        do_op8(8'h80, 8'h80, 1'b0, s, co, lat);
        n_cmp++;
        if ({lat, co, s} !== {32'd8, 1'b1, 8'h00}) begin
            n_err++;
            $display("FAIL reset_mid_fresh: lat=%0d cout=%b sum=%h, want lat=8 cout=1 sum=00", lat, co, s);
        end
    endtask

    task automatic test_width1;
        logic [1:0] fa_tab [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
        logic [1:0] r;
        int         lat;
        for (int i = 0; i < 8; i++) begin
            do_op1(3'(i), r, lat);
            n_cmp++;
            if (lat !== 1 || r !== fa_tab[i]) begin
                n_err++;
                $display("FAIL w1 abc=%03b: lat=%0d {cout,sum}=%b, want lat=1 {cout,sum}=%b", 3'(i), lat, r, fa_tab[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        test_reset();
        test_basic();
        test_carry_chain();
        test_back_to_back();
        test_reset_mid();
        test_width1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
